// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - memory_io types, size encodings and LSU state enum
package load_store_unit_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  do_read;
        logic [3:0]  do_write;
        logic [3:0]  user_tag;
    } memory_io_req32;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [3:0]  user_tag;
    } memory_io_rsp32;

    localparam memory_io_req32 memory_io_no_req32 = '0;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_X = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE2 = 3'd1,
        WAIT1  = 3'd2,
        WAIT2  = 3'd3,
        RESP   = 3'd4
    } lsu_state_t;

    // An access is misaligned when its bytes straddle a word boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SIZE_H) && (off == 2'd3)) || ((size == SIZE_W) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane mask, store data shifting and load extract/extend
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] load_lo,
    input  logic [31:0] load_hi,
    output logic [7:0]  mask,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [31:0] load_data
);

    logic [7:0]  base;
    logic [4:0]  shamt_lo;
    logic [5:0]  shamt_hi;
    logic [31:0] shifted;

    always_comb begin
        case (size)
            SIZE_B:  base = 8'h01;
            SIZE_H:  base = 8'h03;
            SIZE_W:  base = 8'h0F;
            default: base = 8'h00;
        endcase
    end

    assign mask     = base << off;
    assign shamt_lo = {off, 3'b000};
    // Shift of 32 for off = 0 leaves nothing for the second word.
    assign shamt_hi = 6'd32 - {1'b0, shamt_lo};
    assign wdata_lo = wdata << shamt_lo;
    assign wdata_hi = wdata >> shamt_hi;
    assign shifted  = 32'({load_hi, load_lo} >> shamt_lo);

    always_comb begin
        case (size)
            SIZE_B:  load_data = is_unsigned ? {24'h0, shifted[7:0]}   : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_H:  load_data = is_unsigned ? {16'h0, shifted[15:0]}  : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit driving a 32-bit word memory
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int allow_misaligned = 1,
    parameter int addr_width       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic [addr_width-1:0] cpu_req_addr,
    input  logic                  cpu_req_write,
    input  logic [1:0]            cpu_req_size,
    input  logic                  cpu_req_unsigned,
    input  logic [31:0]           cpu_req_wdata,
    output logic                  cpu_rsp_valid,
    output logic [31:0]           cpu_rsp_data,
    output logic                  cpu_rsp_error,
    output memory_io_req32        mem_req,
    input  memory_io_rsp32        mem_rsp
);

    lsu_state_t  state;
    logic [31:0] r_addr;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_write;
    logic        r_unsigned;
    logic        r_split;
    logic [31:0] r_wdata;
    logic [31:0] r_rsp1;

    logic        accept;
    logic        misaligned;
    logic        illegal;
    logic [31:0] aligned_addr;
    logic [1:0]  off_sel;
    logic [1:0]  size_sel;
    logic [31:0] wdata_sel;
    logic [7:0]  mask;
    logic [31:0] wdata_lo;
    logic [31:0] wdata_hi;
    logic [31:0] load_lo;
    logic [31:0] load_hi;
    logic [31:0] load_data;
    logic        unused_rsp_tag;

    assign accept       = cpu_req_valid && cpu_req_ready;
    assign aligned_addr = 32'({cpu_req_addr[addr_width-1:2], 2'b00});
    assign misaligned   = is_misaligned(cpu_req_size, cpu_req_addr[1:0]);
    assign illegal      = (cpu_req_size == SIZE_X) || ((allow_misaligned == 0) && misaligned);

    // In IDLE the aligner works on the live request; afterwards on the held copy.
    assign off_sel   = (state == IDLE) ? cpu_req_addr[1:0] : r_off;
    assign size_sel  = (state == IDLE) ? cpu_req_size      : r_size;
    assign wdata_sel = (state == IDLE) ? cpu_req_wdata     : r_wdata;
    assign load_lo   = (state == WAIT2) ? r_rsp1 : mem_rsp.data;
    assign load_hi   = (state == WAIT2) ? mem_rsp.data : 32'h0;

    assign unused_rsp_tag = ^mem_rsp.user_tag[3:1];

    lsu_align u_align (
        .off         (off_sel),
        .size        (size_sel),
        .is_unsigned (r_unsigned),
        .wdata       (wdata_sel),
        .load_lo     (load_lo),
        .load_hi     (load_hi),
        .mask        (mask),
        .wdata_lo    (wdata_lo),
        .wdata_hi    (wdata_hi),
        .load_data   (load_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cpu_req_ready <= 1'b0;
            cpu_rsp_valid <= 1'b0;
            cpu_rsp_data  <= 32'h0;
            cpu_rsp_error <= 1'b0;
            mem_req       <= memory_io_no_req32;
            r_addr        <= 32'h0;
            r_off         <= 2'd0;
            r_size        <= 2'd0;
            r_write       <= 1'b0;
            r_unsigned    <= 1'b0;
            r_split       <= 1'b0;
            r_wdata       <= 32'h0;
            r_rsp1        <= 32'h0;
        end else begin
            cpu_req_ready <= 1'b0;
            cpu_rsp_valid <= 1'b0;
            cpu_rsp_data  <= 32'h0;
            cpu_rsp_error <= 1'b0;
            mem_req       <= memory_io_no_req32;
            case (state)
                IDLE: begin
                    if (accept) begin
                        r_addr     <= aligned_addr;
                        r_off      <= cpu_req_addr[1:0];
                        r_size     <= cpu_req_size;
                        r_write    <= cpu_req_write;
                        r_unsigned <= cpu_req_unsigned;
                        r_wdata    <= cpu_req_wdata;
                        r_split    <= misaligned;
                        if (illegal) begin
                            cpu_rsp_valid <= 1'b1;
                            cpu_rsp_error <= 1'b1;
                            state         <= RESP;
                        end else begin
                            mem_req.addr     <= aligned_addr;
                            mem_req.data     <= wdata_lo;
                            mem_req.do_read  <= cpu_req_write ? 4'h0 : mask[3:0];
                            mem_req.do_write <= cpu_req_write ? mask[3:0] : 4'h0;
                            mem_req.user_tag <= 4'h0;
                            state            <= misaligned ? ISSUE2 : WAIT1;
                        end
                    end else begin
                        cpu_req_ready <= 1'b1;
                    end
                end
                ISSUE2: begin
                    mem_req.addr     <= r_addr + 32'd4;
                    mem_req.data     <= wdata_hi;
                    mem_req.do_read  <= r_write ? 4'h0 : mask[7:4];
                    mem_req.do_write <= r_write ? mask[7:4] : 4'h0;
                    mem_req.user_tag <= 4'h1;
                    state            <= WAIT1;
                end
                WAIT1: begin
                    if (mem_rsp.valid && !mem_rsp.user_tag[0]) begin
                        if (r_split) begin
                            r_rsp1 <= mem_rsp.data;
                            state  <= WAIT2;
                        end else begin
                            cpu_rsp_valid <= 1'b1;
                            cpu_rsp_data  <= r_write ? 32'h0 : load_data;
                            state         <= RESP;
                        end
                    end
                end
                WAIT2: begin
                    if (mem_rsp.valid && mem_rsp.user_tag[0]) begin
                        cpu_rsp_valid <= 1'b1;
                        cpu_rsp_data  <= r_write ? 32'h0 : load_data;
                        state         <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        valid1 = 1'b0, valid0 = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;

    logic        ready1, ready0, rsp_valid1, rsp_valid0, rsp_error1, rsp_error0;
    logic [31:0] rsp_data1, rsp_data0;
    memory_io_req32 mem_req1, mem_req0, rq;
    memory_io_rsp32 mem_rsp;

    load_store_unit #(.allow_misaligned(1), .addr_width(32)) dut1 (
        .clk(clk), .reset(reset), .cpu_req_valid(valid1), .cpu_req_ready(ready1),
        .cpu_req_addr(req_addr), .cpu_req_write(req_write), .cpu_req_size(req_size),
        .cpu_req_unsigned(req_unsigned), .cpu_req_wdata(req_wdata),
        .cpu_rsp_valid(rsp_valid1), .cpu_rsp_data(rsp_data1), .cpu_rsp_error(rsp_error1),
        .mem_req(mem_req1), .mem_rsp(mem_rsp));

    load_store_unit #(.allow_misaligned(0), .addr_width(32)) dut0 (
        .clk(clk), .reset(reset), .cpu_req_valid(valid0), .cpu_req_ready(ready0),
        .cpu_req_addr(req_addr), .cpu_req_write(req_write), .cpu_req_size(req_size),
        .cpu_req_unsigned(req_unsigned), .cpu_req_wdata(req_wdata),
        .cpu_rsp_valid(rsp_valid0), .cpu_rsp_data(rsp_data0), .cpu_rsp_error(rsp_error0),
        .mem_req(mem_req0), .mem_rsp(mem_rsp));

    // Reference memory as plain bytes; the word memory is reloaded from it on init_mem.
    logic [7:0]  ref_mem [0:1023];
    logic [31:0] mem [0:255];
    logic        init_mem = 1'b0;

    assign rq = mem_req1 | mem_req0;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
            mem_rsp <= '0;
        end else begin
            mem_rsp.valid    <= |{rq.do_read, rq.do_write};
            mem_rsp.data     <= mem[rq.addr[9:2]];
            mem_rsp.user_tag <= rq.user_tag;
            for (int b = 0; b < 4; b++)
                if (rq.do_write[b]) mem[rq.addr[9:2]][8*b +: 8] <= rq.data[8*b +: 8];
        end
    end

    logic use0 = 1'b0;
    logic cur_ready, cur_rsp_valid, cur_rsp_error;
    logic [31:0] cur_rsp_data;
    memory_io_req32 cur_req;
    assign cur_ready     = use0 ? ready0 : ready1;
    assign cur_rsp_valid = use0 ? rsp_valid0 : rsp_valid1;
    assign cur_rsp_error = use0 ? rsp_error0 : rsp_error1;
    assign cur_rsp_data  = use0 ? rsp_data0 : rsp_data1;
    assign cur_req       = use0 ? mem_req0 : mem_req1;

    int n_cmp = 0;
    int n_fail = 0;
    memory_io_req32 reqlog [0:1];
    int reqcyc [0:1];

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        for (int i = 0; i < 4; i++) ref_mem[(a[9:0] & 10'h3FC) + 10'(i)] = v[8*i +: 8];
    endtask

    task automatic load_memory();
        @(negedge clk); init_mem = 1'b1;
        @(negedge clk); init_mem = 1'b0;
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
        logic [31:0] v = '0;
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(a[9:0] + 10'(i))];
        if (!u && n == 1 && v[7])  v = v | 32'hFFFFFF00;
        if (!u && n == 2 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        for (int i = 0; i < nbytes(sz); i++) ref_mem[(a[9:0] + 10'(i))] = wd[8*i +: 8];
    endtask

    task automatic op(input logic sel, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] d, output logic e, output int lat, output int nreq);
        int g;
        logic got;
        @(negedge clk);
        use0 = sel; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        if (sel) valid0 = 1'b1; else valid1 = 1'b1;
        g = 0;
        while (!cur_ready && g < 20) begin @(negedge clk); g++; end
        if (!cur_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout addr=%h ready=%b required 1", a, cur_ready);
        end
        @(posedge clk); #1;
        valid0 = 1'b0; valid1 = 1'b0;
        req_addr = $urandom(); req_wdata = $urandom(); req_size = 2'($urandom()); req_write = 1'($urandom());
        lat = 0; nreq = 0; d = '0; e = 1'b0; got = 1'b0;
        while (!got && lat < 12) begin
            @(negedge clk); lat++;
            if (|{cur_req.do_read, cur_req.do_write}) begin
                if (nreq < 2) begin reqlog[nreq] = cur_req; reqcyc[nreq] = lat; end
                nreq++;
            end
            if (cur_rsp_valid) begin d = cur_rsp_data; e = cur_rsp_error; got = 1'b1; end
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL rsp_timeout addr=%h got no cpu_rsp_valid within %0d cycles", a, lat);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        init_mem = 1'b1;
        repeat (2) @(negedge clk);
        init_mem = 1'b0;
        n_cmp++; if (ready1 !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready1); end
        n_cmp++; if (rsp_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid1); end
        n_cmp++; if (rsp_data1 !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data got %h want 0", rsp_data1); end
        n_cmp++; if (rsp_error1 !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_error got %b want 0", rsp_error1); end
        n_cmp++; if (mem_req1 !== memory_io_no_req32) begin n_fail++; $display("FAIL reset_mem_req got %h want 0", mem_req1); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (ready1 !== 1'b1) begin n_fail++; $display("FAIL ready_after_release got %b want 1", ready1); end
    endtask

    task automatic test_directed();
        logic [31:0] d; logic e; int lat, nreq;
        set_word(32'h100, 32'h8899AABB);
        load_memory();
        op(1'b0, 1'b0, SIZE_B, 1'b0, 32'h101, 32'h0, d, e, lat, nreq);
        n_cmp++; if (d !== 32'hFFFFFFAA) begin n_fail++; $display("FAIL lb_data got %h want ffffffaa", d); end
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL lb_latency got %0d want 3", lat); end
        n_cmp++; if (nreq !== 1 || reqlog[0].do_read !== 4'b0010 || reqlog[0].addr !== 32'h100)
            begin n_fail++; $display("FAIL lb_mem_req got n=%0d rd=%b addr=%h want 1/0010/100", nreq, reqlog[0].do_read, reqlog[0].addr); end

        op(1'b0, 1'b1, SIZE_H, 1'b0, 32'h102, 32'h1234, d, e, lat, nreq);
        ref_store(32'h102, SIZE_H, 32'h1234);
        n_cmp++; if (reqlog[0].do_write !== 4'b1100 || reqlog[0].data[31:16] !== 16'h1234 || reqlog[0].do_read !== 4'h0)
            begin n_fail++; $display("FAIL sh_mem_req got wr=%b data=%h want 1100/1234xxxx", reqlog[0].do_write, reqlog[0].data); end
        n_cmp++; if (d !== 32'h0 || e !== 1'b0 || lat !== 3) begin n_fail++; $display("FAIL sh_rsp got d=%h e=%b lat=%0d want 0/0/3", d, e, lat); end
        op(1'b0, 1'b0, SIZE_W, 1'b0, 32'h100, 32'h0, d, e, lat, nreq);
        n_cmp++; if (d !== 32'h1234AABB) begin n_fail++; $display("FAIL lw_after_sh got %h want 1234aabb", d); end

        set_word(32'h100, 32'h44332211);
        set_word(32'h104, 32'h88776655);
        load_memory();
        op(1'b0, 1'b0, SIZE_W, 1'b0, 32'h103, 32'h0, d, e, lat, nreq);
        n_cmp++; if (d !== 32'h77665544) begin n_fail++; $display("FAIL lw_mis_data got %h want 77665544", d); end
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL lw_mis_latency got %0d want 4", lat); end
        n_cmp++; if (nreq !== 2 || reqcyc[1] !== reqcyc[0] + 1) begin n_fail++; $display("FAIL lw_mis_reqs got n=%0d cyc=%0d,%0d want 2 consecutive", nreq, reqcyc[0], reqcyc[1]); end
        n_cmp++; if (reqlog[0].addr !== 32'h100 || reqlog[0].do_read !== 4'b1000 || reqlog[1].addr !== 32'h104 || reqlog[1].do_read !== 4'b0111)
            begin n_fail++; $display("FAIL lw_mis_parts got %h/%b %h/%b want 100/1000 104/0111", reqlog[0].addr, reqlog[0].do_read, reqlog[1].addr, reqlog[1].do_read); end
    endtask

    task automatic test_no_misaligned();
        logic [31:0] d; logic e; int lat, nreq;
        op(1'b1, 1'b0, SIZE_H, 1'b0, 32'h103, 32'h0, d, e, lat, nreq);
        n_cmp++; if (e !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL strict_lh_rsp got e=%b d=%h want 1/0", e, d); end
        n_cmp++; if (lat !== 1 || nreq !== 0) begin n_fail++; $display("FAIL strict_lh_timing got lat=%0d n=%0d want 1/0", lat, nreq); end
        use0 = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic e; int lat, nreq, g, stray;
        set_word(32'h100, 32'h8899AABB);
        set_word(32'h104, 32'h44332211);
        set_word(32'h108, 32'h88776655);
        load_memory();
        @(negedge clk);
        use0 = 1'b0; req_write = 1'b0; req_size = SIZE_W; req_unsigned = 1'b0; req_addr = 32'h107;
        valid1 = 1'b1;
        g = 0;
        while (!ready1 && g < 20) begin @(negedge clk); g++; end
        @(posedge clk); #1 valid1 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (ready1 !== 1'b0 || rsp_valid1 !== 1'b0 || mem_req1 !== memory_io_no_req32)
            begin n_fail++; $display("FAIL mid_reset_outputs got rdy=%b v=%b req=%h want 0/0/0", ready1, rsp_valid1, mem_req1); end
        #1 reset = 1'b1;
        stray = 0;
        repeat (5) begin @(negedge clk); if (rsp_valid1) stray++; end
        n_cmp++; if (stray !== 0) begin n_fail++; $display("FAIL mid_reset_stray_rsp got %0d responses want 0", stray); end
        op(1'b0, 1'b0, SIZE_B, 1'b1, 32'h100, 32'h0, d, e, lat, nreq);
        n_cmp++; if (d !== 32'h000000BB || lat !== 3) begin n_fail++; $display("FAIL lbu_after_reset got %h lat=%0d want 000000bb/3", d, lat); end
    endtask

    task automatic test_hold_illegal();
        int g, accepts, rsps;
        @(negedge clk);
        use0 = 1'b0; req_size = SIZE_X; req_write = 1'b0; req_addr = 32'h40;
        valid1 = 1'b1;
        g = 0;
        while (!ready1 && g < 20) begin @(negedge clk); g++; end
        accepts = 0; rsps = 0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            if (ready1) accepts++;
            if (rsp_valid1) rsps++;
            n_cmp++; if (ready1 !== (i % 3 == 0)) begin n_fail++; $display("FAIL hold_ready[%0d] got %b want %b", i, ready1, (i % 3 == 0)); end
            n_cmp++; if (rsp_valid1 !== (i % 3 == 1) || (rsp_valid1 && rsp_error1 !== 1'b1))
                begin n_fail++; $display("FAIL hold_rsp[%0d] got v=%b e=%b want v=%b e=1", i, rsp_valid1, rsp_error1, (i % 3 == 1)); end
        end
        @(negedge clk);
        if (rsp_valid1) rsps++;
        valid1 = 1'b0;
        n_cmp++; if (rsps !== accepts) begin n_fail++; $display("FAIL hold_rsp_per_accept got %0d rsp for %0d accepts", rsps, accepts); end
    endtask

    task automatic test_random();
        logic [31:0] d, a, wd, exp_d; logic e, w, u, mis; logic [1:0] sz; int lat, nreq, exp_lat, exp_n;
        for (int k = 0; k < 80; k++) begin
            a = $urandom(); wd = $urandom(); sz = 2'($urandom_range(0, 3));
            w = 1'($urandom()); u = 1'($urandom());
            mis = (sz != SIZE_X) && (int'(a[1:0]) + nbytes(sz) > 4);
            exp_d   = (sz == SIZE_X || w) ? 32'h0 : ref_load(a, sz, u);
            exp_lat = (sz == SIZE_X) ? 1 : mis ? 4 : 3;
            exp_n   = (sz == SIZE_X) ? 0 : mis ? 2 : 1;
            op(1'b0, w, sz, u, a, wd, d, e, lat, nreq);
            if (sz != SIZE_X && w) ref_store(a, sz, wd);
            n_cmp++;
            if (d !== exp_d || e !== (sz == SIZE_X) || lat !== exp_lat || nreq !== exp_n)
                begin n_fail++; $display("FAIL rand[%0d] a=%h sz=%0d w=%b u=%b got d=%h e=%b lat=%0d n=%0d want d=%h e=%b lat=%0d n=%0d",
                    k, a, sz, w, u, d, e, lat, nreq, exp_d, (sz == SIZE_X), exp_lat, exp_n); end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom());
        test_reset();
        test_directed();
        test_no_misaligned();
        test_reset_mid();
        test_hold_illegal();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
